// File: rtl/scaler_down_pad_if.sv
// Pixel-stream and FIFO read-port bundle for scaler_down_pad.
//   pix_req        : display requests the next active pixel
//   fifo_rd_en     : read strobe to the upstream FIFO (combinational)
//   fifo_data      : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   data_out       : output pixel, RGB888
//   data_out_valid : data_out qualifier
// master = scaler side, slave = timing generator / FIFO / encoder side.
interface scaler_down_pad_if;
  logic        pix_req;
  logic        fifo_rd_en;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic [23:0] data_out;
  logic        data_out_valid;

  modport master (
    input  pix_req, fifo_data, fifo_empty,
    output fifo_rd_en, data_out, data_out_valid
  );

  modport slave (
    output pix_req, fifo_data, fifo_empty,
    input  fifo_rd_en, data_out, data_out_valid
  );
endinterface

// File: rtl/scaler_down_pad.sv
// Centres a downscaled image inside an H_DISP x V_DISP output frame and fills
// the surround with BORDER_RGB. Pulled by the display's pixel request; pops
// the frame-buffer FIFO only for pixels inside the centred window (or for every
// pixel in bypass mode). Every request is answered exactly two cycles later.
// Ports:
//   pix_clk, rst_n          : clock, asynchronous active-low reset
//   frame_flag              : start-of-frame pulse; latches geometry and mode
//   scale_state             : 1 = pad mode, 0 = bypass
//   s_width, s_height       : downscaled image size, sampled on frame_flag
//   pix_if (master)         : pixel request / FIFO read / pixel output bundle
//   underflow               : sticky, window pixel requested while FIFO empty
module scaler_down_pad #(
  parameter int unsigned H_DISP     = 1280,
  parameter int unsigned V_DISP     = 720,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic                      pix_clk,
  input  logic                      rst_n,
  input  logic                      frame_flag,
  input  logic                      scale_state,
  input  logic [11:0]               s_width,
  input  logic [11:0]               s_height,
  scaler_down_pad_if.master         pix_if,
  output logic                      underflow
);

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] H_W    = CW'(H_DISP);
  localparam logic [CW-1:0] V_W    = CW'(V_DISP);
  localparam logic [CW-1:0] H_LAST = CW'(H_DISP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_DISP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] w_q, w_d, h_q, h_d;
  logic          scale_q, scale_d;
  logic [CW-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic          underflow_q, underflow_d;
  logic          req_q, req_d, rd_q, rd_d;
  logic [23:0]   data_out_q, data_out_d;
  logic          valid_q, valid_d;

  logic [CW-1:0] left_c, right_c, top_c, bot_c;
  logic          in_win_c, hit_c, rd_en_c;

  // Window borders from the latched geometry; w <= H_DISP so no wrap.
  always_comb begin
    left_c  = (H_W - w_q) >> 1;
    right_c = left_c + w_q;
    top_c   = (V_W - h_q) >> 1;
    bot_c   = top_c + h_q;
  end

  // A frame_flag in the same cycle swallows the request.
  always_comb begin
    in_win_c = (cnt_h_q >= left_c) && (cnt_h_q < right_c) &&
               (cnt_v_q >= top_c)  && (cnt_v_q < bot_c);
    hit_c    = (state_q == ACTIVE) && pix_if.pix_req && !frame_flag &&
               (scale_q ? in_win_c : 1'b1);
    rd_en_c  = hit_c && !pix_if.fifo_empty;
  end

  // Next-state: frame control, raster counters, underflow and output pipe.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    scale_d     = scale_q;
    cnt_h_d     = cnt_h_q;
    cnt_v_d     = cnt_v_q;
    underflow_d = underflow_q;
    req_d       = pix_if.pix_req && !frame_flag;
    rd_d        = rd_en_c;
    data_out_d  = data_out_q;
    valid_d     = req_q;

    if (frame_flag) begin
      w_d         = (s_width  > H_W) ? H_W : s_width;
      h_d         = (s_height > V_W) ? V_W : s_height;
      scale_d     = scale_state;
      cnt_h_d     = '0;
      cnt_v_d     = '0;
      underflow_d = 1'b0;
      state_d     = ACTIVE;
    end else if (state_q == ACTIVE && pix_if.pix_req) begin
      if (cnt_h_q == H_LAST) begin
        cnt_h_d = '0;
        if (cnt_v_q == V_LAST) begin
          cnt_v_d = '0;
          state_d = DONE;
        end else begin
          cnt_v_d = cnt_v_q + CW'(1);
        end
      end else begin
        cnt_h_d = cnt_h_q + CW'(1);
      end
    end

    // Missed window pixel: no stall, the pixel becomes border colour.
    if (hit_c && pix_if.fifo_empty) begin
      underflow_d = 1'b1;
    end

    if (req_q) begin
      data_out_d = rd_q ? pix_if.fifo_data : BORDER_RGB;
    end
  end

  // State register.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      scale_q     <= 1'b1;
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
      underflow_q <= 1'b0;
      req_q       <= 1'b0;
      rd_q        <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      scale_q     <= scale_d;
      cnt_h_q     <= cnt_h_d;
      cnt_v_q     <= cnt_v_d;
      underflow_q <= underflow_d;
      req_q       <= req_d;
      rd_q        <= rd_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
    end
  end

  assign pix_if.fifo_rd_en     = rd_en_c;
  assign pix_if.data_out       = data_out_q;
  assign pix_if.data_out_valid = valid_q;
  assign underflow             = underflow_q;

endmodule

// File: tb/tb_scaler_down_pad.sv
module tb_scaler_down_pad;

  localparam int unsigned HD  = 16;
  localparam int unsigned VD  = 8;
  localparam logic [23:0] BRD = 24'h102030;

  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_flag = 1'b0;
  logic        scale_state = 1'b1;
  logic [11:0] s_width = '0;
  logic [11:0] s_height = '0;
  logic        underflow;

  scaler_down_pad_if bus ();

  scaler_down_pad #(
    .H_DISP     (HD),
    .V_DISP     (VD),
    .BORDER_RGB (BRD)
  ) dut (
    .pix_clk     (pix_clk),
    .rst_n       (rst_n),
    .frame_flag  (frame_flag),
    .scale_state (scale_state),
    .s_width     (s_width),
    .s_height    (s_height),
    .pix_if      (bus.master),
    .underflow   (underflow)
  );

  always #5 pix_clk = ~pix_clk;

  // FIFO model: counting data, first word valid the cycle after the strobe.
  logic [23:0] fifo_val = 24'h000001;
  int          pop_total = 0;
  always @(posedge pix_clk) begin
    if (bus.fifo_rd_en === 1'b1) begin
      bus.fifo_data <= fifo_val;
      fifo_val      <= fifo_val + 24'h1;
      pop_total     <= pop_total + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;

  // Reference model state.
  logic        m_active = 1'b0;
  logic        m_mode = 1'b1;
  int          m_w = 0, m_h = 0;
  int          cx = 0, cy = 0;
  logic        m_under = 1'b0;
  logic [23:0] m_val = 24'h000001;
  logic        h1 = 1'b0, h2 = 1'b0;
  int          ex = -1, ey = -1;
  logic [23:0] sb[$];

  task automatic cyc(input logic req, input logic ff);
    logic [23:0] exp_px;
    logic        win, e_hit, e_rd, emp;
    int          l, r, t, b;
    @(negedge pix_clk);
    checks++;
    assert (bus.data_out_valid === h2) else begin
      errors++; $error("FAIL valid got %0b exp %0b at (%0d,%0d)", bus.data_out_valid, h2, cx, cy);
    end
    checks++;
    assert (underflow === m_under) else begin
      errors++; $error("FAIL underflow got %0b exp %0b at (%0d,%0d)", underflow, m_under, cx, cy);
    end
    if (bus.data_out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++; $error("FAIL scoreboard_underrun got valid exp no output");
      end
      if (sb.size() != 0) begin
        exp_px = sb.pop_front();
        checks++;
        assert (bus.data_out === exp_px) else begin
          errors++; $error("FAIL data_out got %h exp %h", bus.data_out, exp_px);
        end
      end
    end
    emp = m_active && (cx == ex) && (cy == ey);
    bus.pix_req    = req;
    frame_flag     = ff;
    bus.fifo_empty = emp;
    #1;
    l = (HD - m_w) / 2; r = l + m_w;
    t = (VD - m_h) / 2; b = t + m_h;
    win   = !m_mode || (cx >= l && cx < r && cy >= t && cy < b);
    e_hit = m_active && req && !ff && win;
    e_rd  = e_hit && !emp;
    checks++;
    assert (bus.fifo_rd_en === e_rd) else begin
      errors++; $error("FAIL rd_en got %0b exp %0b at (%0d,%0d)", bus.fifo_rd_en, e_rd, cx, cy);
    end
    if (req && !ff) sb.push_back(e_rd ? m_val : BRD);
    if (e_rd) m_val = m_val + 24'h1;
    if (e_hit && emp) m_under = 1'b1;
    if (ff) begin
      m_w      = (int'(s_width)  > HD) ? HD : int'(s_width);
      m_h      = (int'(s_height) > VD) ? VD : int'(s_height);
      m_mode   = scale_state;
      m_active = 1'b1;
      cx = 0; cy = 0;
      m_under  = 1'b0;
    end else if (m_active && req) begin
      if (cx == HD - 1) begin
        cx = 0;
        if (cy == VD - 1) begin cy = 0; m_active = 1'b0; end
        else cy++;
      end else begin
        cx++;
      end
    end
    h2 = h1;
    h1 = req && !ff;
  endtask

  // One full frame, optional request gaps, then requests while DONE.
  task automatic frame(input int sw, input int sh, input logic mode, input logic gap,
                       input logic ff_req, input int exp_pops);
    int start, n, k;
    s_width     = 12'(sw);
    s_height    = 12'(sh);
    scale_state = mode;
    start = pop_total;
    cyc(ff_req, 1'b1);
    n = 0; k = 0;
    while (n < HD * VD) begin
      if (gap && (k % 7 == 3)) cyc(1'b0, 1'b0);
      else begin cyc(1'b1, 1'b0); n++; end
      k++;
    end
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    checks++;
    assert (pop_total - start == exp_pops) else begin
      errors++; $error("FAIL pops %0dx%0d got %0d exp %0d", sw, sh, pop_total - start, exp_pops);
    end
  endtask

  initial begin
    bus.pix_req = 1'b0;
    bus.fifo_empty = 1'b0;
    repeat (3) @(negedge pix_clk);
    #1;
    checks++;
    assert (bus.data_out === 24'h0 && bus.data_out_valid === 1'b0 && underflow === 1'b0
            && bus.fifo_rd_en === 1'b0) else begin
      errors++; $error("FAIL reset got %h/%0b/%0b exp 0/0/0", bus.data_out, bus.data_out_valid, underflow);
    end
    @(negedge pix_clk);
    rst_n = 1'b1;

    // Requests before any frame_flag: border only.
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);

    frame(8, 4, 1'b1, 1'b0, 1'b0, 32);
    frame(7, 3, 1'b1, 1'b1, 1'b0, 21);
    frame(20, 10, 1'b1, 1'b0, 1'b1, 128);
    frame(4, 2, 1'b0, 1'b1, 1'b0, 128);
    frame(0, 5, 1'b1, 1'b0, 1'b0, 0);
    ex = 6; ey = 3;
    frame(8, 4, 1'b1, 1'b0, 1'b0, 31);
    ex = -1; ey = -1;
    frame(8, 4, 1'b1, 1'b0, 1'b0, 32);

    // Reset in the middle of a frame.
    s_width = 12'd8; s_height = 12'd4; scale_state = 1'b1;
    cyc(1'b0, 1'b1);
    repeat (50) cyc(1'b1, 1'b0);
    @(negedge pix_clk);
    rst_n = 1'b0;
    bus.pix_req = 1'b0;
    frame_flag = 1'b0;
    bus.fifo_empty = 1'b0;
    #1;
    checks++;
    assert (bus.data_out === 24'h0 && bus.data_out_valid === 1'b0 && underflow === 1'b0
            && bus.fifo_rd_en === 1'b0) else begin
      errors++; $error("FAIL midreset got %h/%0b/%0b exp 0/0/0", bus.data_out, bus.data_out_valid, underflow);
    end
    m_active = 1'b0; m_mode = 1'b1; m_w = 0; m_h = 0; cx = 0; cy = 0;
    m_under = 1'b0; h1 = 1'b0; h2 = 1'b0; sb.delete();
    @(negedge pix_clk);
    rst_n = 1'b1;
    begin
      int start;
      start = pop_total;
      repeat (10) cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
      checks++;
      assert (pop_total == start) else begin
        errors++; $error("FAIL postreset_pops got %0d exp 0", pop_total - start);
      end
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL leftover got %0d exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
